// File: rtl/cpu_pkg.sv
// Shared pipeline-control types and constants: stall encodings, FSM states, watchdog limits.
package cpu_pkg;

    localparam int unsigned STALL_W = 5;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned TMO_W   = 10;
    localparam int unsigned TMO_MAX = 1023;

    // Hold-enable patterns, one per requesting stage (bit0 PC ... bit4 MEM/WB)
    localparam logic [STALL_W-1:0] STALL_MEM  = 5'b01111;
    localparam logic [STALL_W-1:0] STALL_EXE  = 5'b00111;
    localparam logic [STALL_W-1:0] STALL_ID   = 5'b00011;
    localparam logic [STALL_W-1:0] STALL_IF   = 5'b00001;
    localparam logic [STALL_W-1:0] STALL_NONE = 5'b00000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_FLUSH = 2'd2
    } pipe_state_e;

    // Bubble goes into the first register downstream of the held region
    function automatic logic [STALL_W-1:0] bubble_of(input logic [STALL_W-1:0] stall);
        logic [STALL_W-1:0] b;
        b = '0;
        for (int unsigned k = 0; k < STALL_W - 1; k++) begin
            b[k+1] = stall[k] & ~stall[k+1];
        end
        return b;
    endfunction

endpackage

// File: rtl/stall_watchdog.sv
// Counts consecutive cycles the PC is held; raises a sticky flag once the limit is reached.
module stall_watchdog
    import cpu_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic stall,
    output logic timeout
);

    logic [TMO_W-1:0] cnt;
    logic [TMO_W-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = '0;
        if (stall) begin
            cnt_nxt = (cnt == TMO_W'(TMO_MAX)) ? cnt : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            timeout <= timeout | (cnt_nxt == TMO_W'(TMO_MAX));
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: priority stall/bubble generation plus exception/ERET redirect sequencing.
module pipe_ctrl
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_if_i,
    input  logic               stallreq_id_i,
    input  logic               stallreq_exe_i,
    input  logic               stallreq_mem_i,
    input  logic               exc_valid_i,
    input  logic [ADDR_W-1:0]  exc_handler_i,
    input  logic               eret_i,
    input  logic [ADDR_W-1:0]  epc_i,
    output logic [STALL_W-1:0] stall_o,
    output logic [STALL_W-1:0] bubble_o,
    output logic               flush_o,
    output logic [ADDR_W-1:0]  new_pc_o,
    output logic               pend_o,
    output logic               stall_timeout_o
);

    pipe_state_e       state;
    logic              evt;
    logic [ADDR_W-1:0] target;

    assign evt    = exc_valid_i | eret_i;
    assign target = exc_valid_i ? exc_handler_i : epc_i;

    // Stalls are suppressed during the flush cycle since every register is cleared anyway
    always_comb begin
        stall_o  = STALL_NONE;
        bubble_o = '0;
        if (state != ST_FLUSH) begin
            if (stallreq_mem_i)      stall_o = STALL_MEM;
            else if (stallreq_exe_i) stall_o = STALL_EXE;
            else if (stallreq_id_i)  stall_o = STALL_ID;
            else if (stallreq_if_i)  stall_o = STALL_IF;
            bubble_o = bubble_of(stall_o);
        end
    end

    // Redirect sequencer; the target is captured at the event so later events cannot disturb it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            flush_o  <= 1'b0;
            pend_o   <= 1'b0;
            new_pc_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (evt) begin
                        new_pc_o <= target;
                        if (stallreq_mem_i) begin
                            state  <= ST_PEND;
                            pend_o <= 1'b1;
                        end else begin
                            state   <= ST_FLUSH;
                            flush_o <= 1'b1;
                        end
                    end
                end
                ST_PEND: begin
                    if (!stallreq_mem_i) begin
                        state   <= ST_FLUSH;
                        pend_o  <= 1'b0;
                        flush_o <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    state   <= ST_IDLE;
                    flush_o <= 1'b0;
                end
                default: begin
                    state   <= ST_IDLE;
                    flush_o <= 1'b0;
                    pend_o  <= 1'b0;
                end
            endcase
        end
    end

    stall_watchdog u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .stall   (stall_o[0]),
        .timeout (stall_timeout_o)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: redirect targets are scoreboarded and checked when flush_o fires.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_if_i, stallreq_id_i, stallreq_exe_i, stallreq_mem_i;
    logic        exc_valid_i, eret_i;
    logic [31:0] exc_handler_i, epc_i;
    logic [4:0]  stall_o, bubble_o;
    logic        flush_o, pend_o, stall_timeout_o;
    logic [31:0] new_pc_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    pipe_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .stallreq_if_i   (stallreq_if_i),
        .stallreq_id_i   (stallreq_id_i),
        .stallreq_exe_i  (stallreq_exe_i),
        .stallreq_mem_i  (stallreq_mem_i),
        .exc_valid_i     (exc_valid_i),
        .exc_handler_i   (exc_handler_i),
        .eret_i          (eret_i),
        .epc_i           (epc_i),
        .stall_o         (stall_o),
        .bubble_o        (bubble_o),
        .flush_o         (flush_o),
        .new_pc_o        (new_pc_o),
        .pend_o          (pend_o),
        .stall_timeout_o (stall_timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Flush cycle: pop the queued target and compare against new_pc_o
    task automatic expect_flush(input string tag);
        logic [31:0] exp_pc;
        check({tag, "_flush"}, 32'(flush_o), 32'd1);
        check({tag, "_stall0"}, 32'(stall_o), 32'd0);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_scoreboard: observed=flush expected=no_pending_target", tag);
        end else begin
            exp_pc = exp_q.pop_front();
            check({tag, "_new_pc"}, new_pc_o, exp_pc);
        end
    endtask

    // {mem, exe, id, if} request pattern -> expected stall / bubble
    logic [3:0] req_tab   [6] = '{4'b1111, 4'b0110, 4'b0010, 4'b0001, 4'b0000, 4'b1000};
    logic [4:0] stall_tab [6] = '{5'b01111, 5'b00111, 5'b00011, 5'b00001, 5'b00000, 5'b01111};
    logic [4:0] bub_tab   [6] = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00000, 5'b10000};

    initial begin
        rst = 1'b0;
        {stallreq_mem_i, stallreq_exe_i, stallreq_id_i, stallreq_if_i} = 4'b0000;
        exc_valid_i = 1'b0; eret_i = 1'b0;
        exc_handler_i = 32'h0; epc_i = 32'h0;

        #3;
        check("rst_flush", 32'(flush_o), 32'd0);
        check("rst_pend", 32'(pend_o), 32'd0);
        check("rst_new_pc", new_pc_o, 32'h0);
        check("rst_timeout", 32'(stall_timeout_o), 32'd0);
        stallreq_exe_i = 1'b1;
        #1;
        check("rst_stall_follow", 32'(stall_o), 32'h07);
        check("rst_bubble_follow", 32'(bubble_o), 32'h08);
        stallreq_exe_i = 1'b0;

        @(negedge clk);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            {stallreq_mem_i, stallreq_exe_i, stallreq_id_i, stallreq_if_i} = req_tab[i];
            #1;
            check($sformatf("prio_stall_%0d", i), 32'(stall_o), 32'(stall_tab[i]));
            check($sformatf("prio_bubble_%0d", i), 32'(bubble_o), 32'(bub_tab[i]));
        end
        {stallreq_mem_i, stallreq_exe_i, stallreq_id_i, stallreq_if_i} = 4'b0000;
        tick();

        // Plain exception, with a second event and a stall request during the flush cycle
        exc_valid_i = 1'b1; exc_handler_i = 32'hBFC00380;
        exp_q.push_back(32'hBFC00380);
        tick();
        exc_valid_i = 1'b1; exc_handler_i = 32'h12345678; stallreq_id_i = 1'b1;
        #1;
        expect_flush("exc");
        check("exc_bubble0", 32'(bubble_o), 32'd0);
        tick();
        exc_valid_i = 1'b0; stallreq_id_i = 1'b0;
        check("exc_after_flush", 32'(flush_o), 32'd0);
        check("exc_hold_pc", new_pc_o, 32'hBFC00380);
        tick();
        check("flush_evt_ignored", 32'(flush_o), 32'd0);
        check("flush_evt_no_pend", 32'(pend_o), 32'd0);

        // ERET alone
        eret_i = 1'b1; epc_i = 32'h80000040;
        exp_q.push_back(32'h80000040);
        tick();
        eret_i = 1'b0;
        expect_flush("eret");
        tick();
        check("eret_after_flush", 32'(flush_o), 32'd0);

        // Exception and ERET together: exception wins
        exc_valid_i = 1'b1; eret_i = 1'b1;
        exc_handler_i = 32'hBFC00200; epc_i = 32'h80001000;
        exp_q.push_back(32'hBFC00200);
        tick();
        exc_valid_i = 1'b0; eret_i = 1'b0;
        expect_flush("collide");
        tick();

        // Deferred exception behind a 4-cycle memory stall; a second exception is ignored
        stallreq_mem_i = 1'b1; exc_valid_i = 1'b1; exc_handler_i = 32'hBFC00180;
        exp_q.push_back(32'hBFC00180);
        tick();
        exc_valid_i = 1'b0;
        check("defer_pend_0", 32'(pend_o), 32'd1);
        check("defer_noflush_0", 32'(flush_o), 32'd0);
        check("defer_stall", 32'(stall_o), 32'h0F);
        for (int i = 1; i < 4; i++) begin
            if (i == 1) begin
                exc_valid_i = 1'b1; exc_handler_i = 32'hDEAD0000;
            end
            tick();
            exc_valid_i = 1'b0;
            check($sformatf("defer_pend_%0d", i), 32'(pend_o), 32'd1);
            check($sformatf("defer_noflush_%0d", i), 32'(flush_o), 32'd0);
        end
        stallreq_mem_i = 1'b0;
        tick();
        check("defer_pend_drop", 32'(pend_o), 32'd0);
        expect_flush("defer");
        tick();
        check("defer_after_flush", 32'(flush_o), 32'd0);

        // Watchdog: limit reached after exactly 1023 stalled cycles, then sticky
        stallreq_if_i = 1'b1;
        repeat (1022) tick();
        check("wdog_below", 32'(stall_timeout_o), 32'd0);
        tick();
        check("wdog_rise", 32'(stall_timeout_o), 32'd1);
        stallreq_if_i = 1'b0;
        repeat (3) tick();
        check("wdog_sticky", 32'(stall_timeout_o), 32'd1);

        // Reset while a redirect is pending drops it
        stallreq_mem_i = 1'b1; exc_valid_i = 1'b1; exc_handler_i = 32'hBFC00400;
        tick();
        exc_valid_i = 1'b0;
        check("mid_pend", 32'(pend_o), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_pend", 32'(pend_o), 32'd0);
        check("mid_rst_flush", 32'(flush_o), 32'd0);
        check("mid_rst_pc", new_pc_o, 32'h0);
        check("mid_rst_timeout", 32'(stall_timeout_o), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        stallreq_mem_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("post_rst_noflush_%0d", i), 32'(flush_o), 32'd0);
            check($sformatf("post_rst_nopend_%0d", i), 32'(pend_o), 32'd0);
        end
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
